pipelined_rotate_right_shifter: RTL and testbench
=================================================

// Module: pipelined_rotate_right_shifter
// PURPOSE
//  Registered, back-pressured N-bit rotate-right barrel shifter; companion of the combinational rotate-left unit.
//  Undoes a prior rotate-left: ODATA = IDATA rotated right by N_SHIFT. One log2 stage per pipeline register.
//  Sits between a valid/ready producer and consumer. Accepts one word per cycle; latency = NO_OF_SHIFT_STAGES.
// PARAMETERS
//  DATA_WIDTH         8                     width of IDATA/ODATA; must be a power of 2, >= 2
//  SHIFT_WIDTH        $clog2(DATA_WIDTH)    width of N_SHIFT
//  NO_OF_SHIFT_STAGES SHIFT_WIDTH           pipeline depth; one stage per N_SHIFT bit
// PORTS
//  CLK      in   1            clock; all state updates on posedge CLK
//  RST      in   1            synchronous reset, active-high
//  IVALID   in   1            input word valid
//  IREADY   out  1            block can accept a word this cycle
//  IDATA    in   DATA_WIDTH   word to rotate
//  N_SHIFT  in   SHIFT_WIDTH  rotate-right amount, 0..DATA_WIDTH-1
//  OVALID   out  1            ODATA valid
//  OREADY   in   1            consumer accepts ODATA this cycle
//  ODATA    out  DATA_WIDTH   rotated word
//  BUSY     out  1            OR of all stage valid bits
// BEHAVIOUR
//  - Stage s (s = 0 is input side) holds vld[s], data[s] and the not-yet-applied N_SHIFT bits.
//  - Stage s applies N_SHIFT bit (NO_OF_SHIFT_STAGES-1-s): rotate right by 2**that bit index when the bit is 1.
//    The MSB is applied first; the LSB is applied last.
//  - Handshake: transfer in on IVALID & IREADY; transfer out on OVALID & OREADY.
//  - Hold rule: ODATA must stay stable while OVALID=1 & OREADY=0.
//  - Stage readiness: rdy[last] = ~vld[last] | OREADY; rdy[s] = ~vld[s] | rdy[s+1].
//    IREADY = rdy[0], computed combinationally with no register in the ready path.
//  - Advance: stage s loads from s-1 (or from the input) when rdy[s] is 1.
//    Its vld becomes the upstream valid; otherwise it holds.
//  - Throughput: one word/cycle when OREADY=1 continuously. Latency from accept to OVALID = NO_OF_SHIFT_STAGES cycles.
//  - OVALID = vld[last]; ODATA = data[last].
//  - Reset: all vld <= 0, all data <= 0. OVALID=0, ODATA=0 and BUSY=0 in the cycle after RST is sampled.
//    IREADY=1 once RST deasserts.
//  - Reset mid-operation: every in-flight word is discarded; no partial output appears.
//  - Simultaneous accept and emit on a full pipe: allowed with no bubble (rdy chains through).
//  - N_SHIFT=0: word passes unchanged with the full latency.
//  - The shift value is captured at accept and is unaffected by later N_SHIFT changes.
//  - IVALID may drop without a transfer (no stickiness required). Data on non-valid cycles is don't-care.
//  - No X may reach ODATA after reset, even when vld=0.
// STRUCTURE
//  - Shared package/include: localparams for the stage-index mapping (stage s -> shift bit) and the stage pipe width.
//    Reuse the rotate-left unit's parameter set.
//  - Sub-module: rotate_right_shifter #(DATA_WIDTH, N), a combinational single stage: rotate right by N when SHIFT=1.
//    Instantiate it once per stage in a generate loop, each followed by a valid/data/shift register slice.
//  - Stage registers are kept in flat vectors indexed [s*DATA_WIDTH +: DATA_WIDTH].
// TESTING (DATA_WIDTH=8, latency 3)
//  1. IDATA=0x81, N_SHIFT=1, OREADY=1 -> OVALID high 3 cycles after accept, ODATA=0xC0.
//  2. IDATA=0x01, N_SHIFT=7 -> ODATA=0x02. IDATA=0xA5, N_SHIFT=0 -> ODATA=0xA5.
//  3. Stream 16 words back-to-back, N_SHIFT=i%8, OREADY=1 -> 16 outputs on consecutive cycles, in order,
//     each equal to a reference rotate-right of its input.
//  4. Hold OREADY=0 for 6 cycles while streaming -> IREADY falls after 3 accepts; ODATA stable while stalled;
//     no loss or duplication after OREADY=1.
//  5. Assert RST with 3 words in flight -> next cycle OVALID=0, ODATA=0, BUSY=0; those words never appear.
//  6. Random IVALID/OREADY, 10k words, all N_SHIFT values -> scoreboard match.
//     Check rotl(rotr(x,n),n)==x via the rotate-left unit.

Source files
------------

// File: rtl/pipelined_rotate_right_shifter_pkg.sv
// Shared parameter set of the rotate-left/rotate-right units and the mapping
// from pipeline stage index to the shift bit that stage applies.
package pipelined_rotate_right_shifter_pkg;

  localparam int ROT_DATA_WIDTH  = 8;
  localparam int ROT_SHIFT_WIDTH = $clog2(ROT_DATA_WIDTH);

  // Stage 0 sits on the input side and applies the MSB; the last stage applies the LSB.
  function automatic int stage_shift_bit(input int stage, input int n_stages);
    return n_stages - 1 - stage;
  endfunction

  // One stage slice carries a valid bit, the data word and the captured shift amount.
  function automatic int stage_pipe_width(input int data_width, input int shift_width);
    return 1 + data_width + shift_width;
  endfunction

endpackage

// File: rtl/rotate_right_shifter.sv
// Combinational single rotate stage: rotate right by the fixed amount N when shift is set.
module rotate_right_shifter
  import pipelined_rotate_right_shifter_pkg::*;
#(
  parameter int DATA_WIDTH = ROT_DATA_WIDTH,
  parameter int N          = 1
) (
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] rotated
);

  // N is a power of two strictly below DATA_WIDTH, so both slices are non-empty.
  always_comb begin
    rotated = data;
    if (shift) begin
      rotated = {data[N-1:0], data[DATA_WIDTH-1:N]};
    end else begin
      rotated = data;
    end
  end

endmodule

// File: rtl/pipelined_rotate_right_shifter.sv
// Back-pressured rotate-right barrel shifter: one log2 rotate step per pipeline
// register, valid/ready on both sides, one word per cycle.
module pipelined_rotate_right_shifter
  import pipelined_rotate_right_shifter_pkg::*;
#(
  parameter int DATA_WIDTH         = ROT_DATA_WIDTH,
  parameter int SHIFT_WIDTH        = $clog2(DATA_WIDTH),
  parameter int NO_OF_SHIFT_STAGES = SHIFT_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IVALID,
  output logic                   IREADY,
  input  logic [DATA_WIDTH-1:0]  IDATA,
  input  logic [SHIFT_WIDTH-1:0] N_SHIFT,
  output logic                   OVALID,
  input  logic                   OREADY,
  output logic [DATA_WIDTH-1:0]  ODATA,
  output logic                   BUSY
);

  localparam int DW  = DATA_WIDTH;
  localparam int SW  = SHIFT_WIDTH;
  localparam int NSS = NO_OF_SHIFT_STAGES;

  logic [NSS-1:0]    vld_r;
  logic [NSS*DW-1:0] data_r;
  logic [NSS*SW-1:0] shamt_r;

  logic [NSS-1:0]    rdy_s;
  logic [NSS-1:0]    up_vld_s;
  logic [NSS*DW-1:0] up_data_s;
  logic [NSS*SW-1:0] up_shamt_s;
  logic [NSS*DW-1:0] rot_s;

  for (genvar s = 0; s < NSS; s++) begin : g_stage
    localparam int BIT = stage_shift_bit(s, NSS);

    if (s == 0) begin : g_in
      assign up_vld_s[s]             = IVALID;
      assign up_data_s[s*DW +: DW]   = IDATA;
      assign up_shamt_s[s*SW +: SW]  = N_SHIFT;
    end else begin : g_link
      assign up_vld_s[s]             = vld_r[s-1];
      assign up_data_s[s*DW +: DW]   = data_r[(s-1)*DW +: DW];
      assign up_shamt_s[s*SW +: SW]  = shamt_r[(s-1)*SW +: SW];
    end

    // A stage is free unless it and every stage after it are full while the consumer stalls.
    assign rdy_s[s] = OREADY | ~(&vld_r[NSS-1:s]);

    rotate_right_shifter #(
      .DATA_WIDTH (DW),
      .N          (1 << BIT)
    ) u_rot (
      .shift   (up_shamt_s[s*SW + BIT]),
      .data    (up_data_s[s*DW +: DW]),
      .rotated (rot_s[s*DW +: DW])
    );
  end

  // Stage slices: valid follows upstream when free; payload only loads on a real word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_r   <= '0;
      data_r  <= '0;
      shamt_r <= '0;
    end else begin
      for (int s = 0; s < NSS; s++) begin
        if (rdy_s[s]) begin
          vld_r[s] <= up_vld_s[s];
        end
        if (rdy_s[s] && up_vld_s[s]) begin
          data_r[s*DW +: DW]  <= rot_s[s*DW +: DW];
          shamt_r[s*SW +: SW] <= up_shamt_s[s*SW +: SW];
        end
      end
    end
  end

  // The last stage's captured shift amount has no consumer.
  logic unused_shamt_s;
  assign unused_shamt_s = ^shamt_r[(NSS-1)*SW +: SW];

  assign IREADY = rdy_s[0];
  assign OVALID = vld_r[NSS-1];
  assign ODATA  = data_r[(NSS-1)*DW +: DW];
  assign BUSY   = |vld_r;

endmodule

// File: tb/tb_pipelined_rotate_right_shifter.sv
// Self-checking bench: directed vector table, stall/reset sequences and a
// random valid/ready stream, all checked through an expected-result queue.
module tb_pipelined_rotate_right_shifter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IVALID;
  logic       IREADY;
  logic [7:0] IDATA;
  logic [2:0] N_SHIFT;
  logic       OVALID;
  logic       OREADY;
  logic [7:0] ODATA;
  logic       BUSY;

  pipelined_rotate_right_shifter #(
    .DATA_WIDTH (8)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .IVALID  (IVALID),
    .IREADY  (IREADY),
    .IDATA   (IDATA),
    .N_SHIFT (N_SHIFT),
    .OVALID  (OVALID),
    .OREADY  (OREADY),
    .ODATA   (ODATA),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] din;
    logic [2:0] n;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];
  vec_t mon_e;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  bit drv_done;

  function automatic logic [7:0] rotr(input logic [7:0] x, input logic [2:0] n);
    logic [7:0] r = x;
    for (int k = 0; k < int'(n); k++) r = {r[0], r[7:1]};
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input logic [2:0] n);
    logic [7:0] r = x;
    for (int k = 0; k < int'(n); k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; holds the word until the handshake, returns at posedge+1 after accept.
  task automatic send_one(input logic [7:0] d, input logic [2:0] n);
    int guard = 0;
    IVALID  = 1'b1;
    IDATA   = d;
    N_SHIFT = n;
    forever begin
      @(negedge CLK);
      if (IREADY) break;
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: IREADY stayed 0, expected 1 within 200 cycles");
        break;
      end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    IVALID  = 1'b0;
    IDATA   = 8'($urandom);
    N_SHIFT = 3'($urandom);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    check(name, sb.size(), 0);
    @(posedge CLK); #1;
  endtask

  // Scoreboard monitor: handshakes are judged mid-cycle, ahead of the edge that completes them.
  always @(negedge CLK) begin
    if (!RST) begin
      if (OVALID && OREADY) begin
        out_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: output 0x%0h with empty scoreboard, expected no output", ODATA);
        end else begin
          mon_e = sb.pop_front();
          check("sb_data", ODATA, mon_e.exp);
          check("sb_rotl_roundtrip", rotl(ODATA, mon_e.n), mon_e.din);
        end
      end
      if (IVALID && IREADY) begin
        sb.push_back('{IDATA, N_SHIFT, rotr(IDATA, N_SHIFT)});
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, run, guard, acc, idx, out0;
    logic [7:0] held;
    bit held_vld, took;
    logic [7:0] words[8];

    vecs[0] = '{8'h81, 3'd1, 8'hC0};
    vecs[1] = '{8'h01, 3'd7, 8'h02};
    vecs[2] = '{8'hA5, 3'd0, 8'hA5};
    vecs[3] = '{8'h80, 3'd3, 8'h10};
    vecs[4] = '{8'hF0, 3'd4, 8'h0F};
    vecs[5] = '{8'h12, 3'd2, 8'h84};
    vecs[6] = '{8'h01, 3'd1, 8'h80};
    vecs[7] = '{8'h3C, 3'd6, 8'hF0};
    vecs[8] = '{8'hB7, 3'd5, 8'hBD};

    RST = 1'b1; IVALID = 1'b0; IDATA = 8'h00; N_SHIFT = 3'd0; OREADY = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_ovalid", OVALID, 0);
    check("reset_odata", ODATA, 0);
    check("reset_busy", BUSY, 0);
    @(posedge CLK); #1;
    RST = 1'b0; OREADY = 1'b1;
    @(negedge CLK);
    check("reset_iready", IREADY, 1);
    @(posedge CLK); #1;

    // Directed table: latency and value per vector.
    for (int i = 0; i < 9; i++) begin
      send_one(vecs[i].din, vecs[i].n);
      lat = 0;
      do begin
        @(negedge CLK);
        lat++;
      end while (!OVALID && lat < 20);
      check("tbl_latency", lat, 3);
      check("tbl_data", ODATA, vecs[i].exp);
      @(posedge CLK); #1;
    end
    drain("tbl_drain");

    // Back-to-back stream: outputs must come on consecutive cycles.
    run = 0;
    fork
      for (int i = 0; i < 16; i++) send_one(8'($urandom), 3'(i % 8));
      begin
        guard = 0;
        while (!OVALID && guard < 20) begin @(negedge CLK); guard++; end
        while (OVALID && run < 40) begin run++; @(negedge CLK); end
      end
    join
    check("stream_run", run, 16);
    drain("stream_drain");

    // Consumer stall: three accepts fill the pipe, ODATA holds, nothing lost afterwards.
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    out0 = out_cnt;
    OREADY = 1'b0; idx = 0; acc = 0; held_vld = 1'b0;
    IVALID = 1'b1; IDATA = words[0]; N_SHIFT = 3'd0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      took = IREADY;
      if (took) acc++;
      if (OVALID) begin
        if (!held_vld) begin
          held = ODATA;
          held_vld = 1'b1;
        end else begin
          check("stall_hold", ODATA, held);
        end
      end
      @(posedge CLK); #1;
      if (took) begin
        idx++;
        IDATA = words[idx];
        N_SHIFT = 3'(idx % 8);
      end
    end
    check("stall_accepts", acc, 3);
    check("stall_iready", IREADY, 0);
    check("stall_busy", BUSY, 1);
    OREADY = 1'b1;
    while (idx < 8) begin
      send_one(words[idx], 3'(idx % 8));
      idx++;
    end
    drain("stall_drain");
    check("stall_outputs", out_cnt - out0, 8);

    // Reset with three words in flight: none of them may emerge.
    OREADY = 1'b0;
    for (int i = 0; i < 3; i++) send_one(8'h5A + 8'(i), 3'(i + 1));
    check("flight_busy", BUSY, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    sb.delete();
    @(negedge CLK);
    check("rst_mid_ovalid", OVALID, 0);
    check("rst_mid_odata", ODATA, 0);
    check("rst_mid_busy", BUSY, 0);
    @(posedge CLK); #1;
    RST = 1'b0; OREADY = 1'b1;
    out0 = out_cnt;
    repeat (10) @(negedge CLK);
    check("rst_mid_no_output", out_cnt - out0, 0);
    check("rst_mid_iready", IREADY, 1);
    @(posedge CLK); #1;

    // Random valid/ready traffic over every shift amount.
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          while ($urandom_range(0, 3) == 0) begin
            IDATA = 8'($urandom);
            N_SHIFT = 3'($urandom);
            @(posedge CLK); #1;
          end
          send_one(8'($urandom), 3'($urandom_range(0, 7)));
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          OREADY = ($urandom_range(0, 3) != 0);
          @(posedge CLK); #1;
        end
        OREADY = 1'b1;
      end
    join
    drain("random_drain");
    check("final_idle", BUSY, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
